counter_run_ctrl: RTL and testbench
===================================

Name: counter_run_ctrl

Overview:
Run controller for a WIDTH-bit up counter. Accepts START/STOP/LOAD/SET_LIMIT commands over a valid/ready handshake and sequences the count between a programmable load value and a programmable terminal limit. Supports one-shot and auto-reload runs. It sits beside the small counter blocks and owns their start, pause, terminal-count and reload policy.

Parameters:
WIDTH, 3, counter/load/limit width in bits (≥2)
LIMIT_RST, 2**WIDTH-1, reset value of the limit register

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command this cycle
cmd_op  input  2  00 START, 01 STOP, 10 LOAD, 11 SET_LIMIT
cmd_data  input  WIDTH  operand for LOAD/SET_LIMIT; ignored otherwise
auto_reload  input  1  sampled at terminal count: 1 = reload and keep running, 0 = stop in DONE
count  output  WIDTH  current count value (registered)
busy  output  1  high while state == RUN
tc_pulse  output  1  one-cycle pulse after each terminal-count event
done  output  1  high while state == DONE

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, count=0, load_val=0, limit=LIMIT_RST, cmd_ready=0, tc_pulse=0, busy=0, done=0.
- cmd_ready handshake:
  - registered; goes 1 on the first edge after reset_n deasserts.
  - accept = cmd_valid & cmd_ready.
  - after an accept, cmd_ready=0 for exactly one cycle, then 1. This gives at most one command per 2 cycles.
- States: IDLE, RUN, HOLD, DONE. busy=(RUN), done=(DONE).
- START (accepting edge):
  - IDLE/DONE -> RUN, count<=load_val.
  - HOLD -> RUN, count kept.
  - RUN: accepted, no effect.
- STOP: RUN -> HOLD, count frozen. Accepted with no effect in IDLE, HOLD and DONE.
- LOAD: load_val<=cmd_data. If state≠RUN, count<=cmd_data as well. In RUN only load_val changes and is used at the next reload.
- SET_LIMIT: limit<=cmd_data, used from the next cycle's compare. Allowed in any state.
- RUN counting:
  - count increments by 1 each cycle, modulo 2**WIDTH (7->0 wraps silently).
  - first increment is on the edge after START is accepted.
- Terminal (RUN and count==limit at an edge, no STOP accepted on that edge):
  - auto_reload=1: count<=load_val, stay RUN.
  - auto_reload=0: state->DONE, count holds limit.
  - tc_pulse=1 for the following cycle only.
- Priority on the same edge: accepted STOP beats terminal. Result is HOLD, count unchanged, no tc_pulse.
- load_val>limit: count runs up through the wrap until it equals limit (6,7,0,1,2 for limit 2).
- Limit lowered below count mid-run: counting wraps and terminates on the next match.
- reset_n asserted mid-operation: all registers return to reset values immediately, asynchronously. Any in-flight command is dropped.

Optional Feature:
COUNT_DOWN_EN
- Defined: adds input port cnt_dir (1 bit). In RUN, cnt_dir=1 decrements count by 1 modulo 2**WIDTH (0->max wraps). Terminal and reload rules are unchanged. cnt_dir is sampled every cycle.
- Undefined: no cnt_dir port; up-count only.

Decomposition:
- Package counter_ctrl_pkg:
  - op encodings OP_START/OP_STOP/OP_LOAD/OP_SET_LIMIT (2-bit).
  - state enum IDLE/RUN/HOLD/DONE.
  - default WIDTH constant.
- One sub-module, ctrl_count_core: WIDTH-bit register with load, enable, direction and async active-low reset. The FSM, handshake and compare logic stay in counter_run_ctrl.

Test Plan:
1. Reset, wait for cmd_ready=1, START (defaults, auto_reload=0) -> count 0,1,...,7; tc_pulse one cycle after the 7 edge; done=1, busy=0, count holds 7.
2. LOAD 3, SET_LIMIT 5, auto_reload=1, START -> count 3,4,5,3,4,5,...; tc_pulse once per 5->3 reload; busy stays 1.
3. Running from 0 with limit 7, STOP accepted while count=4 -> HOLD, count=4 for 10 cycles with no tc_pulse; START -> next count 5.
4. LOAD 6, SET_LIMIT 2, auto_reload=0, START -> count 6,7,0,1,2 then DONE with count=2; tc_pulse exactly once.
5. Drive reset_n low mid-RUN at count=5 -> same cycle: count=0, busy=0, cmd_ready=0; after release, limit=7 and load_val=0 (verified by START: count 0 to 7).
6. cmd_valid held 3 cycles with LOAD 2 then LOAD 4 -> first accepted, cmd_ready=0 next cycle, second accepted on the third cycle; final load_val=4.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter run controller.
//   - DEFAULT_WIDTH : default counter/load/limit width
//   - OP_*          : 2-bit command opcodes carried on cmd_op
//   - state_e       : controller states
package counter_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 3;

    localparam logic [1:0] OP_START     = 2'b00;
    localparam logic [1:0] OP_STOP      = 2'b01;
    localparam logic [1:0] OP_LOAD      = 2'b10;
    localparam logic [1:0] OP_SET_LIMIT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/counter_run_ctrl_if.sv
// Command channel of the counter run controller (valid/ready handshake).
//   cmd_valid : command present            (master -> slave)
//   cmd_op    : opcode, see counter_ctrl_pkg (master -> slave)
//   cmd_data  : operand for LOAD/SET_LIMIT (master -> slave)
//   cmd_ready : slave can accept this cycle (slave -> master)
interface counter_run_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/ctrl_count_core.sv
// WIDTH-bit count register with synchronous load, enable and direction.
//   clk, reset_n : clock and asynchronous active-low reset (count -> 0)
//   load_i       : load load_val_i (has priority over en_i)
//   en_i         : step the count by one
//   dir_i        : 0 = increment, 1 = decrement (both wrap modulo 2**WIDTH)
//   count_o      : registered count
module ctrl_count_core #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = dir_i ? (count_q - One) : (count_q + One);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_run_ctrl.sv
// Run controller for a WIDTH-bit counter: START/STOP/LOAD/SET_LIMIT commands
// over a valid/ready channel, one-shot or auto-reload runs between a load
// value and a terminal limit.
//   clk, reset_n  : clock and asynchronous active-low reset
//   cmd_if        : command channel (slave side)
//   auto_reload_i : at terminal count, 1 = reload and keep running, 0 = DONE
//   cnt_dir_i     : only with COUNT_DOWN_EN defined; 1 = count down in RUN
//   count_o       : current count
//   busy_o        : state is RUN
//   tc_pulse_o    : one-cycle pulse after each terminal-count event
//   done_o        : state is DONE
// Optional feature macro: COUNT_DOWN_EN.
module counter_run_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned     WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] LIMIT_RST = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    counter_run_ctrl_if.slave cmd_if,
    input  logic             auto_reload_i,
`ifdef COUNT_DOWN_EN
    input  logic             cnt_dir_i,
`endif
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             tc_pulse_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             cmd_ready_q;
    logic             tc_q, tc_d;
    logic             busy_q, done_q;

    logic             core_load, core_en, dir;
    logic [WIDTH-1:0] core_load_val;
    logic [WIDTH-1:0] count;

    logic accept, is_start, is_stop, is_load, is_set_limit, terminal;

`ifdef COUNT_DOWN_EN
    assign dir = cnt_dir_i;
`else
    assign dir = 1'b0;
`endif

    assign accept       = cmd_if.cmd_valid & cmd_ready_q;
    assign is_start     = accept & (cmd_if.cmd_op == OP_START);
    assign is_stop      = accept & (cmd_if.cmd_op == OP_STOP);
    assign is_load      = accept & (cmd_if.cmd_op == OP_LOAD);
    assign is_set_limit = accept & (cmd_if.cmd_op == OP_SET_LIMIT);

    // An accepted STOP wins over a terminal match on the same edge.
    assign terminal = (state_q == RUN) && (count == limit_q) && !is_stop;

    always_comb begin
        state_d       = state_q;
        load_val_d    = load_val_q;
        limit_d       = limit_q;
        tc_d          = 1'b0;
        core_load     = 1'b0;
        core_load_val = load_val_q;
        core_en       = 1'b0;

        if (is_set_limit) begin
            limit_d = cmd_if.cmd_data;
        end

        // While running, LOAD only stages the value for the next reload.
        if (is_load) begin
            load_val_d = cmd_if.cmd_data;
            if (state_q != RUN) begin
                core_load     = 1'b1;
                core_load_val = cmd_if.cmd_data;
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (is_start) begin
                    state_d       = RUN;
                    core_load     = 1'b1;
                    core_load_val = load_val_q;
                end
            end
            HOLD: begin
                if (is_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (is_stop) begin
                    state_d = HOLD;
                end else if (terminal) begin
                    tc_d = 1'b1;
                    if (auto_reload_i) begin
                        core_load     = 1'b1;
                        core_load_val = load_val_q;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    core_en = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            load_val_q  <= '0;
            limit_q     <= LIMIT_RST;
            cmd_ready_q <= 1'b0;
            tc_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_val_q  <= load_val_d;
            limit_q     <= limit_d;
            // Drop ready for one cycle after every accept.
            cmd_ready_q <= !accept;
            tc_q        <= tc_d;
            busy_q      <= (state_d == RUN);
            done_q      <= (state_d == DONE);
        end
    end

    ctrl_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (core_load),
        .load_val_i (core_load_val),
        .en_i       (core_en),
        .dir_i      (dir),
        .count_o    (count)
    );

    assign cmd_if.cmd_ready = cmd_ready_q;
    assign count_o          = count;
    assign busy_o           = busy_q;
    assign tc_pulse_o       = tc_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed self-checking bench for counter_run_ctrl (WIDTH=3).
module tb_counter_run_ctrl;
    import counter_ctrl_pkg::*;

    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] count;
    logic         busy, tc_pulse, done;
`ifdef COUNT_DOWN_EN
    logic         cnt_dir = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    counter_run_ctrl_if #(.WIDTH(W)) cmd_if ();

    counter_run_ctrl #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_if        (cmd_if),
        .auto_reload_i (auto_reload),
`ifdef COUNT_DOWN_EN
        .cnt_dir_i     (cnt_dir),
`endif
        .count_o       (count),
        .busy_o        (busy),
        .tc_pulse_o    (tc_pulse),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] data);
        int waited = 0;
        while (cmd_if.cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_if.cmd_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_cmd_ready: cmd_ready=%b required 1 within 20 cycles",
                     cmd_if.cmd_ready);
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || tc_pulse !== 1'b0)
            $display("FAIL reset_outputs: count=%0d busy=%b done=%b tc=%b required 0/0/0/0",
                     count, busy, done, tc_pulse);
        else n_pass++;
        n_checks++;
        if (cmd_if.cmd_ready !== 1'b0)
            $display("FAIL reset_ready: got %b required 0", cmd_if.cmd_ready);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_if.cmd_ready !== 1'b1)
            $display("FAIL ready_after_reset: got %b required 1", cmd_if.cmd_ready);
        else n_pass++;
    endtask

    task automatic test_one_shot();
        auto_reload = 1'b0;
        send_cmd(OP_START, '0);
        n_checks++;
        if (count !== 3'd0 || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL one_shot_start: count=%0d busy=%b done=%b required 0/1/0",
                     count, busy, done);
        else n_pass++;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            n_checks++;
            if (count !== W'(i) || tc_pulse !== 1'b0)
                $display("FAIL one_shot_count: count=%0d tc=%b required %0d/0", count, tc_pulse, i);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (count !== 3'd7 || tc_pulse !== 1'b1 || done !== 1'b1 || busy !== 1'b0)
            $display("FAIL one_shot_done: count=%0d tc=%b done=%b busy=%b required 7/1/1/0",
                     count, tc_pulse, done, busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (count !== 3'd7 || tc_pulse !== 1'b0 || done !== 1'b1)
            $display("FAIL one_shot_hold: count=%0d tc=%b done=%b required 7/0/1",
                     count, tc_pulse, done);
        else n_pass++;
    endtask

    task automatic test_auto_reload();
        logic [W-1:0] exp_c;
        logic         exp_tc;
        send_cmd(OP_LOAD, 3'd3);
        n_checks++;
        if (count !== 3'd3)
            $display("FAIL load_not_run: count=%0d required 3", count);
        else n_pass++;
        send_cmd(OP_SET_LIMIT, 3'd5);
        auto_reload = 1'b1;
        send_cmd(OP_START, '0);
        n_checks++;
        if (count !== 3'd3 || busy !== 1'b1)
            $display("FAIL reload_start: count=%0d busy=%b required 3/1", count, busy);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_c  = (i % 3 == 0) ? 3'd4 : (i % 3 == 1) ? 3'd5 : 3'd3;
            exp_tc = (i % 3 == 2);
            n_checks++;
            if (count !== exp_c || tc_pulse !== exp_tc || busy !== 1'b1)
                $display("FAIL reload_seq: count=%0d tc=%b busy=%b required %0d/%b/1",
                         count, tc_pulse, busy, exp_c, exp_tc);
            else n_pass++;
        end
        auto_reload = 1'b0;
        send_cmd(OP_STOP, '0);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reload_stop: busy=%b done=%b required 0/0", busy, done);
        else n_pass++;
    endtask

    task automatic test_stop_hold();
        int waited = 0;
        send_cmd(OP_LOAD, 3'd0);
        send_cmd(OP_SET_LIMIT, 3'd7);
        send_cmd(OP_START, '0);
        n_checks++;
        if (count !== 3'd0 || busy !== 1'b1)
            $display("FAIL hold_start: count=%0d busy=%b required 0/1", count, busy);
        else n_pass++;
        while (count !== 3'd4 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (count !== 3'd4 || waited != 4 || cmd_if.cmd_ready !== 1'b1)
            $display("FAIL hold_reach4: count=%0d cycles=%0d ready=%b required 4/4/1",
                     count, waited, cmd_if.cmd_ready);
        else n_pass++;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_STOP;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (count !== 3'd4 || tc_pulse !== 1'b0 || busy !== 1'b0)
                $display("FAIL hold_frozen: count=%0d tc=%b busy=%b required 4/0/0",
                         count, tc_pulse, busy);
            else n_pass++;
            @(negedge clk);
        end
        send_cmd(OP_START, '0);
        n_checks++;
        if (count !== 3'd4 || busy !== 1'b1)
            $display("FAIL hold_resume: count=%0d busy=%b required 4/1", count, busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (count !== 3'd5)
            $display("FAIL hold_next: count=%0d required 5", count);
        else n_pass++;
        send_cmd(OP_STOP, '0);
    endtask

    task automatic test_wrap_limit();
        logic [W-1:0] exp_c [0:7];
        int           tc_seen = 0;
        exp_c = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
        send_cmd(OP_LOAD, 3'd6);
        send_cmd(OP_SET_LIMIT, 3'd2);
        auto_reload = 1'b0;
        send_cmd(OP_START, '0);
        n_checks++;
        if (count !== 3'd6)
            $display("FAIL wrap_start: count=%0d required 6", count);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tc_pulse === 1'b1) tc_seen++;
            n_checks++;
            if (count !== exp_c[i] || done !== (i >= 4))
                $display("FAIL wrap_seq: step=%0d count=%0d done=%b required %0d/%b",
                         i, count, done, exp_c[i], (i >= 4));
            else n_pass++;
        end
        n_checks++;
        if (tc_seen != 1)
            $display("FAIL wrap_tc_count: got %0d pulses required 1", tc_seen);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int waited = 0;
        send_cmd(OP_SET_LIMIT, 3'd7);
        send_cmd(OP_LOAD, 3'd0);
        send_cmd(OP_START, '0);
        while (count !== 3'd5 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (count !== 3'd5 || busy !== 1'b1)
            $display("FAIL areset_reach5: count=%0d busy=%b required 5/1", count, busy);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL areset_immediate: count=%0d busy=%b ready=%b done=%b required 0/0/0/0",
                     count, busy, cmd_if.cmd_ready, done);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        send_cmd(OP_START, '0);
        n_checks++;
        if (count !== 3'd0 || busy !== 1'b1)
            $display("FAIL areset_restart: count=%0d busy=%b required 0/1", count, busy);
        else n_pass++;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            n_checks++;
            if (count !== W'(i))
                $display("FAIL areset_count: count=%0d required %0d", count, i);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || count !== 3'd7)
            $display("FAIL areset_limit: done=%b count=%0d required 1/7", done, count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_LOAD;
        cmd_if.cmd_data  = 3'd2;
        @(negedge clk);
        n_checks++;
        if (cmd_if.cmd_ready !== 1'b0 || count !== 3'd2)
            $display("FAIL b2b_first: ready=%b count=%0d required 0/2", cmd_if.cmd_ready, count);
        else n_pass++;
        cmd_if.cmd_data = 3'd4;
        @(negedge clk);
        n_checks++;
        if (cmd_if.cmd_ready !== 1'b1 || count !== 3'd2)
            $display("FAIL b2b_gap: ready=%b count=%0d required 1/2", cmd_if.cmd_ready, count);
        else n_pass++;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        n_checks++;
        if (cmd_if.cmd_ready !== 1'b0 || count !== 3'd4)
            $display("FAIL b2b_second: ready=%b count=%0d required 0/4", cmd_if.cmd_ready, count);
        else n_pass++;
        send_cmd(OP_START, '0);
        n_checks++;
        if (count !== 3'd4 || busy !== 1'b1)
            $display("FAIL b2b_loadval: count=%0d busy=%b required 4/1", count, busy);
        else n_pass++;
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_START;
        cmd_if.cmd_data  = '0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_stop_hold();
        test_wrap_limit();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
